// File: rtl/mdu_sequencer_pkg.sv
// Shared types for the multi-cycle multiply/divide sequencer.
package mdu_sequencer_pkg;

    localparam int unsigned MDU_CNT_W  = 7;
    localparam int unsigned MDU_WORD_W = 32;

    typedef enum logic [2:0] {
        MDU_MUL  = 3'd0,
        MDU_DIV  = 3'd1,
        MDU_DIVU = 3'd2,
        MDU_REM  = 3'd3,
        MDU_REMU = 3'd4
    } mdu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mdu_state_t;

    // Control fields latched with an accepted op.
    typedef struct packed {
        mdu_op_t op;
        logic    is_word;
    } mdu_ctl_t;

    function automatic logic op_is_signed(input mdu_op_t op);
        return (op == MDU_DIV) || (op == MDU_REM);
    endfunction

    function automatic logic op_is_rem(input mdu_op_t op);
        return (op == MDU_REM) || (op == MDU_REMU);
    endfunction

    function automatic logic op_is_div(input mdu_op_t op);
        return op != MDU_MUL;
    endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One bit of restoring division: shift the next dividend bit into the
// partial remainder and subtract the divisor if it fits.
module mdu_div_step #(
    parameter int unsigned XLEN = 64
) (
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] quo,
    input  logic [XLEN-1:0] dvs,
    output logic [XLEN-1:0] rem_next,
    output logic [XLEN-1:0] quo_next
);

    logic [XLEN:0] trial;
    logic [XLEN:0] diff;

    // Trial subtract; the borrow bit decides the quotient bit.
    always_comb begin
        trial = {rem, quo[XLEN-1]};
        diff  = trial - {1'b0, dvs};
        if (!diff[XLEN]) begin
            rem_next = diff[XLEN-1:0];
            quo_next = {quo[XLEN-2:0], 1'b1};
        end else begin
            rem_next = trial[XLEN-1:0];
            quo_next = {quo[XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/mdu_sequencer.sv
// Multi-cycle multiply/divide sequencer, one bit per cycle.
// Optional feature macro: MDU_EARLY_OUT_EN (MUL leaves CALC once the
// remaining multiplier is zero).
module mdu_sequencer
    import mdu_sequencer_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_op,
    input  logic            req_is_word,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    input  logic            flush,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_data,
    output logic            busy
);

    localparam int unsigned HI_W = XLEN - MDU_WORD_W;

    mdu_state_t      state;
    mdu_ctl_t        ctl;
    logic [MDU_CNT_W-1:0] cnt;
    logic [XLEN-1:0] acc;   // product accumulator / partial remainder
    logic [XLEN-1:0] sh;    // remaining multiplier / dividend-quotient shifter
    logic [XLEN-1:0] opnd;  // shifted multiplicand / divisor magnitude
    logic            neg_q;
    logic            neg_r;

    // Sign-extend the low word for word ops, pass through otherwise.
    function automatic logic [XLEN-1:0] fit(input logic w, input logic [XLEN-1:0] x);
        return w ? {{HI_W{x[MDU_WORD_W-1]}}, x[MDU_WORD_W-1:0]} : x;
    endfunction

    // Request-side decode
    mdu_op_t                 in_op;
    logic                    in_signed;
    logic                    a_neg;
    logic                    b_neg;
    logic [XLEN-1:0]         a_mag;
    logic [XLEN-1:0]         b_mag;
    logic [MDU_WORD_W-1:0]   a_lo;
    logic [MDU_WORD_W-1:0]   b_lo;
    logic                    b_zero;
    logic                    ovf;
    logic                    special;
    logic [XLEN-1:0]         spec_res;
    logic [XLEN-1:0]         start_sh;
    logic [XLEN-1:0]         start_opnd;

    // Operand decode at the accept edge: magnitudes, special cases, start values.
    always_comb begin
        in_op     = mdu_op_t'(req_op);
        in_signed = op_is_signed(in_op);
        a_lo      = req_a[MDU_WORD_W-1:0];
        b_lo      = req_b[MDU_WORD_W-1:0];
        if (req_is_word) begin
            a_neg  = in_signed & a_lo[MDU_WORD_W-1];
            b_neg  = in_signed & b_lo[MDU_WORD_W-1];
            a_mag  = {{HI_W{1'b0}}, (a_neg ? -a_lo : a_lo)};
            b_mag  = {{HI_W{1'b0}}, (b_neg ? -b_lo : b_lo)};
            b_zero = (b_lo == '0);
            ovf    = in_signed && (a_lo == {1'b1, {(MDU_WORD_W-1){1'b0}}}) && (b_lo == '1);
        end else begin
            a_neg  = in_signed & req_a[XLEN-1];
            b_neg  = in_signed & req_b[XLEN-1];
            a_mag  = a_neg ? -req_a : req_a;
            b_mag  = b_neg ? -req_b : req_b;
            b_zero = (req_b == '0);
            ovf    = in_signed && (req_a == {1'b1, {(XLEN-1){1'b0}}}) && (req_b == '1);
        end
        special = op_is_div(in_op) && (b_zero || ovf);
        if (op_is_rem(in_op)) begin
            spec_res = b_zero ? fit(req_is_word, req_a) : '0;
        end else begin
            spec_res = b_zero ? '1 : fit(req_is_word, req_a);
        end
        if (op_is_div(in_op)) begin
            start_sh   = req_is_word ? {a_mag[MDU_WORD_W-1:0], {MDU_WORD_W{1'b0}}} : a_mag;
            start_opnd = b_mag;
        end else begin
            start_sh   = req_is_word ? {{HI_W{1'b0}}, b_lo} : req_b;
            start_opnd = req_a;
        end
    end

    // Iteration datapath
    logic [XLEN-1:0] mul_acc_nxt;
    logic [XLEN-1:0] mul_sh_nxt;
    logic [XLEN-1:0] mul_opnd_nxt;
    logic [XLEN-1:0] div_rem_nxt;
    logic [XLEN-1:0] div_quo_nxt;
    logic            last_step;
    logic            calc_done;
    logic [XLEN-1:0] calc_res;

    mdu_div_step #(.XLEN(XLEN)) u_div_step (
        .rem      (acc),
        .quo      (sh),
        .dvs      (opnd),
        .rem_next (div_rem_nxt),
        .quo_next (div_quo_nxt)
    );

    // Shift-add step, exit condition and final result formatting.
    always_comb begin
        mul_acc_nxt  = acc + (sh[0] ? opnd : '0);
        mul_sh_nxt   = sh >> 1;
        mul_opnd_nxt = opnd << 1;
        last_step    = (cnt == (ctl.is_word ? MDU_CNT_W'(MDU_WORD_W - 1) : MDU_CNT_W'(XLEN - 1)));
`ifdef MDU_EARLY_OUT_EN
        calc_done    = last_step || ((ctl.op == MDU_MUL) && (mul_sh_nxt == '0));
`else
        calc_done    = last_step;
`endif
        case (ctl.op)
            MDU_MUL:           calc_res = fit(ctl.is_word, mul_acc_nxt);
            MDU_REM, MDU_REMU: calc_res = fit(ctl.is_word, neg_r ? -div_rem_nxt : div_rem_nxt);
            default:           calc_res = fit(ctl.is_word, neg_q ? -div_quo_nxt : div_quo_nxt);
        endcase
    end

    // Sequencer FSM with registered handshake outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            ctl        <= '0;
            cnt        <= '0;
            acc        <= '0;
            sh         <= '0;
            opnd       <= '0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            busy       <= 1'b0;
        end else if (flush) begin
            state      <= IDLE;
            cnt        <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        ctl.op      <= in_op;
                        ctl.is_word <= req_is_word;
                        cnt         <= '0;
                        busy        <= 1'b1;
                        req_ready   <= 1'b0;
                        if (special) begin
                            state      <= DONE;
                            resp_valid <= 1'b1;
                            resp_data  <= spec_res;
                        end else begin
                            state <= CALC;
                            acc   <= '0;
                            sh    <= start_sh;
                            opnd  <= start_opnd;
                            neg_q <= a_neg ^ b_neg;
                            neg_r <= a_neg;
                        end
                    end
                end
                CALC: begin
                    cnt <= cnt + MDU_CNT_W'(1);
                    if (ctl.op == MDU_MUL) begin
                        acc  <= mul_acc_nxt;
                        sh   <= mul_sh_nxt;
                        opnd <= mul_opnd_nxt;
                    end else begin
                        acc <= div_rem_nxt;
                        sh  <= div_quo_nxt;
                    end
                    if (calc_done) begin
                        state      <= DONE;
                        resp_valid <= 1'b1;
                        resp_data  <= calc_res;
                    end
                end
                DONE: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                        busy       <= 1'b0;
                        req_ready  <= 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Self-checking bench for mdu_sequencer: transaction-level reference model,
// per-cycle output compare, directed literal cases and random ops.
module tb_mdu_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic        req_is_word;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic        flush;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_data;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    localparam logic [2:0] OP_MUL = 3'd0, OP_DIV = 3'd1, OP_DIVU = 3'd2, OP_REM = 3'd3, OP_REMU = 3'd4;

    mdu_sequencer #(.XLEN(64)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_is_word (req_is_word),
        .req_a       (req_a),
        .req_b       (req_b),
        .flush       (flush),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_data   (resp_data),
        .busy        (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural result from plain integer arithmetic.
    function automatic logic [63:0] ref_result(input logic [2:0] op, input logic w,
                                               input logic [63:0] a, input logic [63:0] b);
        logic [31:0]     r32;
        logic [63:0]     r64;
        int              sa, sb;
        int unsigned     ua, ub;
        longint          la, lb;
        longint unsigned lua, lub;
        if (w) begin
            ua = a[31:0]; ub = b[31:0];
            sa = int'(ua); sb = int'(ub);
            case (op)
                OP_MUL:  r32 = ua * ub;
                OP_DIV:  r32 = (ub == 0) ? 32'hFFFF_FFFF :
                               (ua == 32'h8000_0000 && ub == 32'hFFFF_FFFF) ? ua : 32'(sa / sb);
                OP_REM:  r32 = (ub == 0) ? ua :
                               (ua == 32'h8000_0000 && ub == 32'hFFFF_FFFF) ? 32'd0 : 32'(sa % sb);
                OP_DIVU: r32 = (ub == 0) ? 32'hFFFF_FFFF : ua / ub;
                default: r32 = (ub == 0) ? ua : ua % ub;
            endcase
            return {{32{r32[31]}}, r32};
        end
        lua = a; lub = b; la = longint'(lua); lb = longint'(lub);
        case (op)
            OP_MUL:  r64 = lua * lub;
            OP_DIV:  r64 = (lub == 0) ? 64'hFFFF_FFFF_FFFF_FFFF :
                           (lua == 64'h8000_0000_0000_0000 && lub == 64'hFFFF_FFFF_FFFF_FFFF) ? lua : 64'(la / lb);
            OP_REM:  r64 = (lub == 0) ? lua :
                           (lua == 64'h8000_0000_0000_0000 && lub == 64'hFFFF_FFFF_FFFF_FFFF) ? 64'd0 : 64'(la % lb);
            OP_DIVU: r64 = (lub == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : lua / lub;
            default: r64 = (lub == 0) ? lua : lua % lub;
        endcase
        return r64;
    endfunction

    // Cycles from accept edge until resp_valid is seen (special cases = 1).
    function automatic int ref_lat(input logic [2:0] op, input logic w,
                                   input logic [63:0] a, input logic [63:0] b);
        logic [63:0] bb;
        logic [63:0] aa;
        int          bl;
        bb = w ? {32'd0, b[31:0]} : b;
        aa = w ? {32'd0, a[31:0]} : a;
        if (op != OP_MUL) begin
            if (bb == 0) return 1;
            if ((op == OP_DIV || op == OP_REM) &&
                ((w && aa == 64'h8000_0000 && bb == 64'hFFFF_FFFF) ||
                 (!w && aa == 64'h8000_0000_0000_0000 && bb == 64'hFFFF_FFFF_FFFF_FFFF)))
                return 1;
        end
`ifdef MDU_EARLY_OUT_EN
        if (op == OP_MUL) begin
            bl = 0;
            for (int i = 0; i < 64; i++) if (bb[i]) bl = i + 1;
            return 1 + ((bl < 1) ? 1 : bl);
        end
`endif
        bl = w ? 32 : 64;
        return bl + 1;
    endfunction

    // Transaction model: 0 = idle, 1 = computing, 2 = result held.
    int          m_mode = 0;
    int          m_wait = 0;
    logic [63:0] m_data = '0;

    always @(posedge clk or posedge reset) begin
        int lat;
        if (reset) begin
            m_mode = 0;
        end else if (flush) begin
            m_mode = 0;
        end else begin
            case (m_mode)
                0: if (req_valid) begin
                    m_data = ref_result(req_op, req_is_word, req_a, req_b);
                    lat    = ref_lat(req_op, req_is_word, req_a, req_b);
                    if (lat == 1) m_mode = 2;
                    else begin m_mode = 1; m_wait = lat - 1; end
                end
                1: begin
                    m_wait--;
                    if (m_wait == 0) m_mode = 2;
                end
                default: if (resp_ready) m_mode = 0;
            endcase
        end
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        if (!reset) begin
            chki("req_ready", int'(req_ready), int'(m_mode == 0));
            chki("busy", int'(busy), int'(m_mode != 0));
            chki("resp_valid", int'(resp_valid), int'(m_mode == 2));
            if (m_mode == 2) chk64("resp_data", resp_data, m_data);
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!req_ready && n < 300) begin @(negedge clk); n++; end
        if (!req_ready) chki("req_ready_timeout", 0, 1);
    endtask

    // Present one op; returns at the negedge after the accept edge.
    task automatic start_op(input logic [2:0] op, input logic w,
                            input logic [63:0] a, input logic [63:0] b, output int acc_cyc);
        wait_ready();
        req_valid = 1'b1; req_op = op; req_is_word = w; req_a = a; req_b = b;
        @(negedge clk);
        acc_cyc   = cyc;
        req_valid = 1'b0;
    endtask

    task automatic run_op(input logic [2:0] op, input logic w, input logic [63:0] a,
                          input logic [63:0] b, input int hold,
                          output logic [63:0] data, output int lat);
        int acc_cyc;
        int n = 0;
        start_op(op, w, a, b, acc_cyc);
        while (!resp_valid && n < 200) begin @(negedge clk); n++; end
        if (!resp_valid) chki("resp_timeout", 0, 1);
        lat  = cyc - acc_cyc + 1;
        data = resp_data;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chki("hold_req_ready", int'(req_ready), 0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 7))
            0: return 64'd0;
            1: return 64'd1;
            2: return 64'hFFFF_FFFF_FFFF_FFFF;
            3: return 64'h8000_0000_0000_0000;
            4: return 64'h0000_0000_8000_0000;
            5: return 64'($urandom_range(0, 100));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        logic [63:0] d;
        int          lat;
        int          acc_cyc;
        logic [2:0]  op;
        logic        w;
        logic [63:0] a, b;

        reset = 1'b1; req_valid = 1'b0; req_op = '0; req_is_word = 1'b0;
        req_a = '0; req_b = '0; flush = 1'b0; resp_ready = 1'b0;
        repeat (3) @(negedge clk);
        chki("rst_req_ready", int'(req_ready), 1);
        chki("rst_resp_valid", int'(resp_valid), 0);
        chki("rst_busy", int'(busy), 0);
        chk64("rst_resp_data", resp_data, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // 64-bit MUL 7 * -3
        run_op(OP_MUL, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 0, d, lat);
        chk64("mul_7x-3", d, 64'hFFFF_FFFF_FFFF_FFEB);
        chki("mul_lat", lat, 65);

        // DIVW / REMW -7 / 2
        run_op(OP_DIV, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 0, d, lat);
        chk64("divw", d, 64'hFFFF_FFFF_FFFF_FFFD);
        chki("divw_lat", lat, 33);
        run_op(OP_REM, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 0, d, lat);
        chk64("remw", d, 64'hFFFF_FFFF_FFFF_FFFF);

        // Divide by zero
        run_op(OP_DIVU, 1'b0, 64'd42, 64'd0, 0, d, lat);
        chk64("divu_by0", d, 64'hFFFF_FFFF_FFFF_FFFF);
        chki("divu_by0_lat", lat, 1);
        run_op(OP_REMU, 1'b0, 64'd42, 64'd0, 0, d, lat);
        chk64("remu_by0", d, 64'd42);

        // Signed overflow
        run_op(OP_DIV, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 0, d, lat);
        chk64("div_ovf", d, 64'h8000_0000_0000_0000);
        chki("div_ovf_lat", lat, 1);
        run_op(OP_REM, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 0, d, lat);
        chk64("rem_ovf", d, 64'd0);

        // MUL by zero: latency depends on the early-out build
        run_op(OP_MUL, 1'b0, 64'd123, 64'd0, 0, d, lat);
        chk64("mul_by0", d, 64'd0);
`ifdef MDU_EARLY_OUT_EN
        chki("mul_by0_lat", lat, 2);
`else
        chki("mul_by0_lat", lat, 65);
`endif

        // Flush at CALC cycle 10, then a clean MUL
        start_op(OP_MUL, 1'b0, 64'd99, 64'hFFFF_FFFF_0000_0001, acc_cyc);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chki("flush_idle", int'(req_ready), 1);
        repeat (80) begin
            @(negedge clk);
            if (resp_valid) chki("flush_no_resp", 1, 0);
        end
        run_op(OP_MUL, 1'b0, 64'd3, 64'd5, 0, d, lat);
        chk64("mul_3x5", d, 64'd15);

        // Flush beats a same-cycle request in IDLE
        req_valid = 1'b1; req_op = OP_DIVU; req_is_word = 1'b0; req_a = 64'd9; req_b = 64'd0;
        flush = 1'b1;
        @(negedge clk);
        req_valid = 1'b0; flush = 1'b0;
        chki("flush_drop_req", int'(busy), 0);

        // Flush beats resp_ready in DONE
        start_op(OP_DIVU, 1'b0, 64'd5, 64'd0, acc_cyc);
        flush = 1'b1; resp_ready = 1'b1;
        @(negedge clk);
        flush = 1'b0; resp_ready = 1'b0;
        chki("flush_done_valid", int'(resp_valid), 0);

        // Hold resp_ready low 5 cycles in DONE
        run_op(OP_DIVU, 1'b0, 64'd100, 64'd7, 5, d, lat);
        chk64("hold_divu", d, 64'd14);

        // Async reset mid-CALC
        start_op(OP_DIV, 1'b0, 64'd1000, 64'd3, acc_cyc);
        repeat (10) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chki("arst_req_ready", int'(req_ready), 1);
        chki("arst_resp_valid", int'(resp_valid), 0);
        chki("arst_busy", int'(busy), 0);
        chk64("arst_resp_data", resp_data, 64'd0);
        @(negedge clk);
        #1 reset = 1'b0;
        @(negedge clk);

        // Random ops, with occasional flushes
        for (int it = 0; it < 250; it++) begin
            op = 3'($urandom_range(0, 4));
            w  = 1'($urandom_range(0, 1));
            a  = pick();
            b  = pick();
            if ($urandom_range(0, 9) == 0) begin
                start_op(op, w, a, b, acc_cyc);
                repeat ($urandom_range(0, 70)) @(negedge clk);
                flush = 1'b1;
                @(negedge clk);
                flush = 1'b0;
            end else begin
                run_op(op, w, a, b, $urandom_range(0, 3), d, lat);
                chk64("rand_data", d, ref_result(op, w, a, b));
                chki("rand_lat", lat, ref_lat(op, w, a, b));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
